sipo_deframer: RTL and testbench

//  Serial-in/parallel-out receive stage; consumes the MSB-first bit stream of the PISO shifter and rebuilds W-bit words.
//  A start strobe aligns word boundaries and a bit counter/FSM tracks position in the word.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_out_slot.sv | 34 +++
 rtl/sipo_deframer.sv | 123 ++++++++++++
 tb/tb_sipo_deframer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deframer.
// SIPO_PARITY_EN adds the PARITY state for the trailing parity bit.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SIPO_PARITY_EN
        , PARITY
`endif
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry valid/ready output slot. A load while full and not draining is
// refused and reported through ovf_set.
module sipo_out_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] word,
    input  logic         perr,
    input  logic         pout_ready,
    output logic [W-1:0] pout,
    output logic         pout_valid,
    output logic         parity_err,
    output logic         ovf_set
);

    assign ovf_set = load & pout_valid & ~pout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
            parity_err <= 1'b0;
        end else if (load && (!pout_valid || pout_ready)) begin
            pout       <= word;
            pout_valid <= 1'b1;
            parity_err <= perr;
        end else if (pout_valid && pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out receive stage: MSB-first bits to W-bit words.
// Define SIPO_PARITY_EN to expect a parity bit after each word.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int W          = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         start,
    output logic [W-1:0] pout,
    output logic         pout_valid,
    input  logic         pout_ready,
    output logic         frame_err,
    output logic         overflow,
    output logic         parity_err
);

    localparam int CW = cnt_w(W);

    if (W < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("sipo_deframer: W must be >= 2 and PARITY_ODD 0 or 1");
    end

    // Without parity the last bit goes straight from sin to the slot, so
    // only W-1 bits ever need to be held.
`ifdef SIPO_PARITY_EN
    localparam int SRW = W;
`else
    localparam int SRW = W - 1;
`endif

    state_t           state, state_n;
    logic [SRW-1:0]   sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ferr_n;
    logic             load;
    logic [W-1:0]     word;
    logic             perr;
    logic             ovf_set;
    logic [W-1:0]     shifted;

    assign shifted = {sr[W-2:0], sin};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            frame_err <= ferr_n;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        ferr_n  = 1'b0;
        load    = 1'b0;
        word    = shifted;
        perr    = 1'b0;
        if (sin_en) begin
            if (start) begin
                ferr_n  = (state != IDLE);
                sr_n    = SRW'(sin);
                cnt_n   = CW'(1);
                state_n = SHIFT;
            end else begin
                case (state)
                    IDLE: ;
                    SHIFT: begin
                        sr_n = SRW'(shifted);
                        if (cnt == CW'(W - 1)) begin
                            cnt_n = '0;
`ifdef SIPO_PARITY_EN
                            state_n = PARITY;
`else
                            load    = 1'b1;
                            state_n = IDLE;
`endif
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        load    = 1'b1;
                        word    = sr;
                        perr    = (^{sr, sin}) != (PARITY_ODD != 0);
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
`endif
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    sipo_out_slot #(.W(W)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .word       (word),
        .perr       (perr),
        .pout_ready (pout_ready),
        .pout       (pout),
        .pout_valid (pout_valid),
        .parity_err (parity_err),
        .ovf_set    (ovf_set)
    );

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer (W=4): vector table, hand-written
// corner sequences and randomized traffic against a bit-level reference model.
module tb_sipo_deframer;

    localparam int W   = 4;
    localparam int ODD = 0;
`ifdef SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, sin, sin_en, start, pout_ready;
    logic [W-1:0] pout;
    logic         pout_valid, frame_err, overflow, parity_err;

    int total = 0;
    int bad   = 0;

    // reference model: frame position as a bit count, word as an integer
    bit m_in_frame = 0;
    int m_nbits    = 0;
    int m_word     = 0;
    bit m_valid    = 0;
    int m_slot     = 0;
    bit m_perr     = 0;
    bit m_ovf      = 0;
    bit m_ferr     = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.W(W), .PARITY_ODD(ODD)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .start      (start),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    task automatic model_update(input bit r, input bit e, input bit s, input bit b, input bit rd);
        bit deliver = 0;
        int dword   = 0;
        bit dperr   = 0;
        if (r) begin
            m_in_frame = 0; m_nbits = 0; m_word = 0;
            m_valid = 0; m_slot = 0; m_perr = 0; m_ovf = 0; m_ferr = 0;
            return;
        end
        m_ferr = 0;
        if (e) begin
            if (s) begin
                m_ferr     = m_in_frame;
                m_in_frame = 1;
                m_nbits    = 1;
                m_word     = int'(b);
            end else if (m_in_frame) begin
                if (m_nbits < W) begin
                    m_word  = m_word * 2 + int'(b);
                    m_nbits = m_nbits + 1;
                    if (m_nbits == W && !PAR) begin
                        deliver = 1; dword = m_word; m_in_frame = 0;
                    end
                end else begin
                    deliver = 1; dword = m_word; m_in_frame = 0;
                    dperr = (($countones(m_word) + int'(b)) % 2) != ODD;
                end
            end
        end
        if (deliver && (!m_valid || rd)) begin
            m_slot = dword; m_valid = 1; m_perr = dperr;
        end else begin
            if (deliver) m_ovf = 1;
            if (m_valid && rd) m_valid = 0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic b, input logic rd);
        rst = r; sin_en = e; start = s; sin = b; pout_ready = rd;
        model_update(r, e, s, b, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] ep, input logic ev,
                       input logic ef, input logic eo, input logic epe);
        total++;
        if (pout !== ep || pout_valid !== ev || frame_err !== ef ||
            overflow !== eo || parity_err !== epe) begin
            bad++;
            $display("FAIL %s: got pout=%h valid=%b ferr=%b ovf=%b perr=%b, want pout=%h valid=%b ferr=%b ovf=%b perr=%b",
                     name, pout, pout_valid, frame_err, overflow, parity_err, ep, ev, ef, eo, epe);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic rd);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, i == 0, w[W-1-i], rd);
        if (PAR) step(1'b0, 1'b1, 1'b0, (^w) ^ (ODD != 0), rd);
    endtask

    typedef struct {
        logic r, e, s, b, rd;
        logic [W-1:0] ep;
        logic ev, ef, eo;
    } vec_t;

    initial begin
`ifndef SIPO_PARITY_EN
        vec_t tbl[13];
        // word 1011 with ready high, then aborted 1,0 followed by 0110
        tbl[0]  = '{1, 0, 0, 0, 0, 4'h0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 1, 4'h0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 1, 4'h0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 1, 4'h0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 1, 4'hB, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 4'hB, 0, 0, 0};
        tbl[6]  = '{0, 1, 1, 1, 1, 4'hB, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 1, 4'hB, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 1, 4'hB, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 1, 4'hB, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 1, 1, 4'hB, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 1, 4'h6, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 4'h6, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].b, tbl[i].rd);
            chk($sformatf("vec%0d", i), tbl[i].ep, tbl[i].ev, tbl[i].ef, tbl[i].eo, 1'b0);
        end
`endif

        // slot full: second word dropped and overflow sticks
        step(1, 0, 0, 0, 0);
        chk("reset", 4'h0, 0, 0, 0, 0);
        send_frame(4'hA, 1'b0);
        chk("ovf_first", 4'hA, 1, 0, 0, 0);
        send_frame(4'h5, 1'b0);
        chk("ovf_drop", 4'hA, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("ovf_drain", 4'hA, 0, 0, 1, 0);

        // sin_en gap inside a word delays completion
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        chk("gap_hold", 4'h0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        if (PAR) step(0, 1, 0, 0, 1);
        chk("gap_penult", 4'h0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        chk("gap_done", 4'hC, 1, 0, 0, 0);

        // reset mid-word with a full slot
        step(1, 0, 0, 0, 0);
        send_frame(4'h9, 1'b0);
        chk("rst_slot", 4'h9, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        chk("rst_clear", 4'h0, 0, 0, 0, 0);
        send_frame(4'h3, 1'b1);
        chk("rst_after", 4'h3, 1, 0, 0, 0);

`ifdef SIPO_PARITY_EN
        step(1, 0, 0, 0, 0);
        send_frame(4'hB, 1'b1);
        chk("par_ok", 4'hB, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 1);
        chk("par_bad", 4'hB, 1, 0, 0, 1);
`endif

        // randomized traffic against the reference model
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 2) != 0);
            chk("rand", W'(m_slot), m_valid, m_ferr, m_ovf, m_perr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
